elastic_eager_fork_ctx: RTL and testbench

- Parametrised eager fork: one elastic input token is broadcast to OUT_NUM elastic outputs.
- Each enabled branch completes independently; a branch that has already taken the token is not re-offered it while slower branches stall.
- A configurable token counter pulses switch_context after a programmed number of fully-delivered tokens. A synchronous flush abandons in-flight state.
- Sits between a PE output register and the neighbour links in the CGRA elastic network.

---
 rtl/elastic_pkg.sv | 20 ++
 rtl/elastic_eager_fork_ctx_if.sv | 47 ++++
 rtl/eager_fork_branch.sv | 61 ++++++
 rtl/elastic_eager_fork_ctx_chk.sv | 37 +++
 rtl/elastic_eager_fork_ctx.sv | 117 +++++++++++
 tb/tb_elastic_eager_fork_ctx.sv | 251 +++++++++++++++++++++++++
 6 files changed

// File: rtl/elastic_pkg.sv
// ---------------------------------------------------------------------------
// elastic_pkg
// Shared definitions for the CGRA elastic network blocks.
//   DEFAULT_DATA_WIDTH : default token payload width
//   NEIGHBOR_PE_NUM    : number of neighbour links a PE output fans out to
//   DEFAULT_CNT_WIDTH  : default width of per-context token counters
//   branch_slice()     : low bit index of branch i on a flat multi-branch bus
// ---------------------------------------------------------------------------
package elastic_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int NEIGHBOR_PE_NUM    = 4;
  localparam int DEFAULT_CNT_WIDTH  = 8;

  // Low bit of branch i on a flat bus of width-bit lanes.
  function automatic int branch_slice(input int i, input int width = DEFAULT_DATA_WIDTH);
    return i * width;
  endfunction

endpackage : elastic_pkg

// File: rtl/elastic_eager_fork_ctx_if.sv
// ---------------------------------------------------------------------------
// elastic_eager_fork_ctx_if
// Handshake bundle of the eager fork: one elastic input channel and OUT_NUM
// elastic output channels plus the per-branch enable mask.
//   input_data / valid_input / stop_input      : producer side
//   output_data / valid_output / stop_output   : consumer side (flat bus)
//   available_output                           : branch enable mask
// Modports:
//   master : the environment (drives the producer and consumer inputs)
//   slave  : the fork itself
// ---------------------------------------------------------------------------
interface elastic_eager_fork_ctx_if
  import elastic_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OUT_NUM    = NEIGHBOR_PE_NUM
);

  logic [DATA_WIDTH-1:0]         input_data;
  logic                          valid_input;
  logic                          stop_input;
  logic [OUT_NUM*DATA_WIDTH-1:0] output_data;
  logic [OUT_NUM-1:0]            valid_output;
  logic [OUT_NUM-1:0]            stop_output;
  logic [OUT_NUM-1:0]            available_output;

  modport master (
    output input_data,
    output valid_input,
    output stop_output,
    output available_output,
    input  stop_input,
    input  output_data,
    input  valid_output
  );

  modport slave (
    input  input_data,
    input  valid_input,
    input  stop_output,
    input  available_output,
    output stop_input,
    output output_data,
    output valid_output
  );

endinterface : elastic_eager_fork_ctx_if

// File: rtl/eager_fork_branch.sv
// ---------------------------------------------------------------------------
// eager_fork_branch
// One branch of the eager fork. Remembers whether this branch already took
// the current token so it is not offered the token a second time while
// slower branches are still stalled.
//   clk, reset_n   : clock, asynchronous active-low reset
//   valid_input    : token present at the fork input
//   available      : branch enabled
//   stop           : backpressure from this branch's consumer
//   flush          : synchronous abort of the current token
//   accept         : fork consumes the input token this cycle
//   valid_output   : token offered to this branch
//   xfer           : token handed over to this branch this cycle
//   done           : branch needs nothing more for the current token
// ---------------------------------------------------------------------------
module eager_fork_branch (
  input  logic clk,
  input  logic reset_n,
  input  logic valid_input,
  input  logic available,
  input  logic stop,
  input  logic flush,
  input  logic accept,
  output logic valid_output,
  output logic xfer,
  output logic done
);

  logic sent_r;
  logic sent_nxt_s;

  // Offer, transfer and completion decode for this branch.
  always_comb begin
    valid_output = valid_input & available & ~sent_r & ~flush;
    xfer         = valid_output & ~stop;
    // A disabled branch never holds the token back.
    done         = ~available | sent_r | xfer;
  end

  // Next value of the sent flag: clear wins over set.
  always_comb begin
    sent_nxt_s = sent_r;
    if (flush || accept) begin
      sent_nxt_s = 1'b0;
    end else if (xfer) begin
      sent_nxt_s = 1'b1;
    end else begin
      sent_nxt_s = sent_r;
    end
  end

  // Sent flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sent_r <= 1'b0;
    end else begin
      sent_r <= sent_nxt_s;
    end
  end

endmodule : eager_fork_branch

// File: rtl/elastic_eager_fork_ctx_chk.sv
// ---------------------------------------------------------------------------
// elastic_eager_fork_ctx_chk
// Invariant checker for the eager fork; observes only.
//   clk, reset_n           : clock, asynchronous active-low reset
//   flush, valid_input     : fork control inputs
//   stop_input             : producer backpressure
//   valid_output           : per-branch valid
//   switch_context         : end-of-context pulse
//   token_count            : tokens accepted in the current context
// ---------------------------------------------------------------------------
module elastic_eager_fork_ctx_chk #(
  parameter int OUT_NUM   = 4,
  parameter int CNT_WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  input logic                 flush,
  input logic                 valid_input,
  input logic                 stop_input,
  input logic [OUT_NUM-1:0]   valid_output,
  input logic                 switch_context,
  input logic [CNT_WIDTH-1:0] token_count
);

  // The producer is only ever stopped while it presents a token.
  a_stop_needs_valid : assert property (@(posedge clk) disable iff (!reset_n)
    stop_input |-> valid_input);

  // Nothing is offered downstream while a flush is in progress.
  a_no_valid_in_flush : assert property (@(posedge clk) disable iff (!reset_n)
    flush |-> (valid_output == {OUT_NUM{1'b0}}));

  // The end-of-context pulse always coincides with a cleared counter.
  a_switch_clears_count : assert property (@(posedge clk) disable iff (!reset_n)
    switch_context |-> (token_count == {CNT_WIDTH{1'b0}}));

endmodule : elastic_eager_fork_ctx_chk

// File: rtl/elastic_eager_fork_ctx.sv
// ---------------------------------------------------------------------------
// elastic_eager_fork_ctx
// Eager fork with context token counter. One input token is broadcast to
// OUT_NUM outputs; each enabled branch completes independently and the input
// is consumed in the cycle the last outstanding branch transfers. After
// token_count_cfg fully delivered tokens switch_context pulses for one cycle.
//   clk, reset_n     : clock, asynchronous active-low reset
//   bus (slave)      : input/output handshakes and branch enable mask
//   token_count_cfg  : tokens per context, 0 disables context switching
//   flush            : synchronous abort of current token and counter
//   switch_context   : registered one-cycle end-of-context pulse
//   token_count      : tokens accepted in the current context
// ---------------------------------------------------------------------------
module elastic_eager_fork_ctx
  import elastic_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OUT_NUM    = NEIGHBOR_PE_NUM,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  elastic_eager_fork_ctx_if.slave  bus,
  input  logic [CNT_WIDTH-1:0]     token_count_cfg,
  input  logic                     flush,
  output logic                     switch_context,
  output logic [CNT_WIDTH-1:0]     token_count
);

  logic [OUT_NUM-1:0]   done_s;
  logic [OUT_NUM-1:0]   xfer_s;
  logic                 all_done_s;
  logic                 accept_s;
  logic                 terminal_s;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] cnt_nxt_s;
  logic                 switch_r;
  logic                 switch_nxt_s;

  // Per-branch broadcast of the payload and branch state.
  for (genvar i = 0; i < OUT_NUM; i++) begin : g_branch
    assign bus.output_data[branch_slice(i, DATA_WIDTH) +: DATA_WIDTH] = bus.input_data;

    eager_fork_branch u_branch (
      .clk          (clk),
      .reset_n      (reset_n),
      .valid_input  (bus.valid_input),
      .available    (bus.available_output[i]),
      .stop         (bus.stop_output[i]),
      .flush        (flush),
      .accept       (accept_s),
      .valid_output (bus.valid_output[i]),
      .xfer         (xfer_s[i]),
      .done         (done_s[i])
    );
  end

  // Accept decode. An empty enable mask must stall rather than drop tokens,
  // hence the OR-reduce on the mask.
  always_comb begin
    all_done_s     = (&done_s) & (|bus.available_output);
    accept_s       = bus.valid_input & all_done_s & ~flush;
    bus.stop_input = bus.valid_input & ~accept_s;
  end

  // Counter and end-of-context decode.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    switch_nxt_s = 1'b0;
    // Equality only: a cfg lowered below the running count lets the
    // counter run on and wrap before it terminates.
    terminal_s   = (token_count_cfg != {CNT_WIDTH{1'b0}}) &&
                   (cnt_r == (token_count_cfg - {{(CNT_WIDTH-1){1'b0}}, 1'b1}));
    if (flush) begin
      cnt_nxt_s    = {CNT_WIDTH{1'b0}};
      switch_nxt_s = 1'b0;
    end else if (accept_s && terminal_s) begin
      cnt_nxt_s    = {CNT_WIDTH{1'b0}};
      switch_nxt_s = 1'b1;
    end else if (accept_s) begin
      cnt_nxt_s    = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      switch_nxt_s = 1'b0;
    end else begin
      cnt_nxt_s    = cnt_r;
      switch_nxt_s = 1'b0;
    end
  end

  // Counter and switch_context registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= {CNT_WIDTH{1'b0}};
      switch_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      switch_r <= switch_nxt_s;
    end
  end

  assign switch_context = switch_r;
  assign token_count    = cnt_r;

  elastic_eager_fork_ctx_chk #(
    .OUT_NUM   (OUT_NUM),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_chk (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (flush),
    .valid_input    (bus.valid_input),
    .stop_input     (bus.stop_input),
    .valid_output   (bus.valid_output),
    .switch_context (switch_r),
    .token_count    (cnt_r)
  );

endmodule : elastic_eager_fork_ctx

// File: tb/tb_elastic_eager_fork_ctx.sv
module tb_elastic_eager_fork_ctx;

  localparam int DW = 32;
  localparam int ON = 4;
  localparam int CW = 8;

  logic          clk;
  logic          reset_n;
  logic [CW-1:0] token_count_cfg;
  logic          flush;
  logic          switch_context;
  logic [CW-1:0] token_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  elastic_eager_fork_ctx_if #(.DATA_WIDTH(DW), .OUT_NUM(ON)) bus ();

  elastic_eager_fork_ctx #(.DATA_WIDTH(DW), .OUT_NUM(ON), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .token_count_cfg (token_count_cfg),
    .flush           (flush),
    .switch_context  (switch_context),
    .token_count     (token_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0;
    bus.valid_input = 1'b0;
    bus.input_data = 32'h0;
    bus.stop_output = 4'b0000;
    bus.available_output = 4'b1111;
    token_count_cfg = 8'd0;
    flush = 1'b0;
    #12;
    total_cnt++;
    if (token_count !== 8'd0) $display("FAIL reset_count got %0d want 0", token_count);
    else pass_cnt++;
    total_cnt++;
    if (switch_context !== 1'b0) $display("FAIL reset_switch got %b want 0", switch_context);
    else pass_cnt++;
    total_cnt++;
    if (bus.valid_output !== 4'b0000 || bus.stop_input !== 1'b0)
      $display("FAIL reset_idle got valid %b stop %b want 0000 0", bus.valid_output, bus.stop_input);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_pass_through();
    logic [31:0] d;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      d = 32'hA1 + k;
      bus.input_data = d;
      bus.valid_input = 1'b1;
      #1;
      total_cnt++;
      if (bus.valid_output !== 4'b1111 || bus.stop_input !== 1'b0)
        $display("FAIL pass_hs tok %0d got valid %b stop %b want 1111 0", k, bus.valid_output, bus.stop_input);
      else pass_cnt++;
      total_cnt++;
      if (bus.output_data !== {4{d}})
        $display("FAIL pass_data tok %0d got %h want %h", k, bus.output_data, {4{d}});
      else pass_cnt++;
    end
    @(negedge clk);
    bus.valid_input = 1'b0;
    #1;
    total_cnt++;
    if (token_count !== 8'd4) $display("FAIL pass_count got %0d want 4", token_count);
    else pass_cnt++;
  endtask

  task automatic test_branch_stall();
    logic [3:0] exp_v [4];
    logic       exp_s [4];
    exp_v = '{4'b1111, 4'b0100, 4'b0100, 4'b0100};
    exp_s = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.input_data = 32'hB1;
      bus.valid_input = 1'b1;
      bus.stop_output = (c < 3) ? 4'b0100 : 4'b0000;
      #1;
      total_cnt++;
      if (bus.valid_output !== exp_v[c] || bus.stop_input !== exp_s[c])
        $display("FAIL stall_cyc%0d got valid %b stop %b want %b %b", c, bus.valid_output, bus.stop_input, exp_v[c], exp_s[c]);
      else pass_cnt++;
    end
    @(negedge clk);
    bus.valid_input = 1'b0;
    #1;
    total_cnt++;
    if (token_count !== 8'd5 || bus.valid_output !== 4'b0000)
      $display("FAIL stall_after got count %0d valid %b want 5 0000", token_count, bus.valid_output);
    else pass_cnt++;
  endtask

  task automatic test_partial_mask();
    bus.available_output = 4'b0101;
    bus.stop_output = 4'b1010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.input_data = 32'hC1 + k;
      bus.valid_input = 1'b1;
      #1;
      total_cnt++;
      if (bus.valid_output !== 4'b0101 || bus.stop_input !== 1'b0)
        $display("FAIL mask_tok%0d got valid %b stop %b want 0101 0", k, bus.valid_output, bus.stop_input);
      else pass_cnt++;
    end
    @(negedge clk);
    bus.available_output = 4'b0000;
    #1;
    total_cnt++;
    if (bus.valid_output !== 4'b0000 || bus.stop_input !== 1'b1)
      $display("FAIL mask_empty got valid %b stop %b want 0000 1", bus.valid_output, bus.stop_input);
    else pass_cnt++;
    @(negedge clk);
    bus.valid_input = 1'b0;
    bus.available_output = 4'b1111;
    bus.stop_output = 4'b0000;
    #1;
    total_cnt++;
    if (token_count !== 8'd7) $display("FAIL mask_count got %0d want 7", token_count);
    else pass_cnt++;
  endtask

  task automatic test_context();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    total_cnt++;
    if (token_count !== 8'd0) $display("FAIL ctx_flush_count got %0d want 0", token_count);
    else pass_cnt++;
    token_count_cfg = 8'd3;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k > 1) begin
        total_cnt++;
        if (switch_context !== (((k - 1) % 3) == 0))
          $display("FAIL ctx_switch after tok %0d got %b want %b", k - 1, switch_context, (((k - 1) % 3) == 0));
        else pass_cnt++;
        total_cnt++;
        if (token_count !== 8'((k - 1) % 3))
          $display("FAIL ctx_count after tok %0d got %0d want %0d", k - 1, token_count, (k - 1) % 3);
        else pass_cnt++;
      end
      bus.input_data = 32'hD0 + k;
      bus.valid_input = (k <= 7);
    end
    @(negedge clk);
    total_cnt++;
    if (switch_context !== 1'b0) $display("FAIL ctx_switch_idle got %b want 0", switch_context);
    else pass_cnt++;
    token_count_cfg = 8'd0;
  endtask

  task automatic test_flush();
    bus.available_output = 4'b0011;
    bus.stop_output = 4'b0010;
    @(negedge clk);
    bus.input_data = 32'hE1;
    bus.valid_input = 1'b1;
    #1;
    total_cnt++;
    if (bus.valid_output !== 4'b0011 || bus.stop_input !== 1'b1)
      $display("FAIL flush_first got valid %b stop %b want 0011 1", bus.valid_output, bus.stop_input);
    else pass_cnt++;
    @(negedge clk);
    flush = 1'b1;
    #1;
    total_cnt++;
    if (bus.valid_output !== 4'b0000 || bus.stop_input !== 1'b1)
      $display("FAIL flush_cyc got valid %b stop %b want 0000 1", bus.valid_output, bus.stop_input);
    else pass_cnt++;
    @(negedge clk);
    flush = 1'b0;
    bus.stop_output = 4'b0000;
    #1;
    total_cnt++;
    if (bus.valid_output !== 4'b0011 || bus.stop_input !== 1'b0)
      $display("FAIL flush_reoffer got valid %b stop %b want 0011 0", bus.valid_output, bus.stop_input);
    else pass_cnt++;
    total_cnt++;
    if (token_count !== 8'd0) $display("FAIL flush_count got %0d want 0", token_count);
    else pass_cnt++;
    @(negedge clk);
    bus.valid_input = 1'b0;
    bus.available_output = 4'b1111;
    #1;
    total_cnt++;
    if (token_count !== 8'd1) $display("FAIL flush_after_count got %0d want 1", token_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bus.stop_output = 4'b1000;
    @(negedge clk);
    bus.input_data = 32'hF1;
    bus.valid_input = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if (bus.valid_output !== 4'b1000 || token_count !== 8'd1)
      $display("FAIL rmid_before got valid %b count %0d want 1000 1", bus.valid_output, token_count);
    else pass_cnt++;
    #1;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.valid_output !== 4'b1111 || token_count !== 8'd0 || switch_context !== 1'b0)
      $display("FAIL rmid_async got valid %b count %0d sw %b want 1111 0 0", bus.valid_output, token_count, switch_context);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    bus.stop_output = 4'b0000;
    #1;
    total_cnt++;
    if (bus.valid_output !== 4'b1111 || bus.stop_input !== 1'b0)
      $display("FAIL rmid_release got valid %b stop %b want 1111 0", bus.valid_output, bus.stop_input);
    else pass_cnt++;
    @(negedge clk);
    bus.valid_input = 1'b0;
    #1;
    total_cnt++;
    if (token_count !== 8'd1) $display("FAIL rmid_count got %0d want 1", token_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_branch_stall();
    test_partial_mask();
    test_context();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_elastic_eager_fork_ctx
